// File: rtl/piso_serializer4.sv
// piso_serializer4: parallel-in, serial-out shifter with valid/ready load
// handshake, ser_en pacing and first/last framing markers. Back-to-back
// words are accepted on the final-bit consume cycle, so frames need no gap.
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the loaded word) as an extra beat after each frame. With the macro
// undefined the frame is exactly WIDTH bits and ser_last marks the last data bit.

module piso_serializer4 #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q,   cnt_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             consume;
    logic             last_data;
    logic             frame_end;
    logic             load;
    logic [WIDTH-1:0] shreg_shifted;

    // Output decode from the current state; all outputs are functions of flops only.
    always_comb begin
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        busy      = (state_q != StIdle);
        case (state_q)
            StShift: begin
                ser_valid = 1'b1;
                ser_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                ser_first = (cnt_q == '0);
`ifdef PISO_PARITY_EN
                // The parity beat carries the frame's last marker instead.
                ser_last  = 1'b0;
`else
                ser_last  = (cnt_q == LastCnt);
`endif
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                ser_valid = 1'b1;
                ser_out   = parity_q;
                ser_last  = 1'b1;
            end
`endif
            default: begin
                ser_valid = 1'b0;
            end
        endcase
    end

    // Handshake decode: a beat is consumed when valid and enabled; the frame's
    // final consume reopens in_ready so the next word loads without a bubble.
    always_comb begin
        consume   = ser_valid & ser_en;
        last_data = (state_q == StShift) && (cnt_q == LastCnt);
`ifdef PISO_PARITY_EN
        frame_end = consume && (state_q == StParity);
`else
        frame_end = consume && last_data;
`endif
        // Reset wins: never advertise readiness while rst is asserted.
        in_ready  = !rst && ((state_q == StIdle) || frame_end);
        load      = in_ready && in_valid;
    end

    // Shift toward the output end, zero-filling the vacated end.
    always_comb begin
        if (MSB_FIRST) begin
            shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: load takes priority, otherwise advance on consume.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (load) begin
            state_d = StShift;
            shreg_d = in_data;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^in_data;
`endif
        end else if (consume) begin
            case (state_q)
                StShift: begin
                    shreg_d = shreg_shifted;
                    if (last_data) begin
                        // Counter wraps to 0 so it never exceeds WIDTH-1.
                        cnt_d = '0;
`ifdef PISO_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
